inverse_lifting_block: RTL and testbench

- Streaming inverse integer 5/3 lifting transform (synthesis side of the DWT datapath).
- Consumes approximation/detail coefficient pairs (an, dn) and rebuilds the time-domain ECG sample stream x[0..2N+1], one sample per output handshake.
- Sits downstream of coefficient storage/thresholding; used for reconstruction checks and for denoised-signal output.
- Boundary handling is symmetric extension, matching the forward transform: d[-1]=d[0], x[2N+2]=x[2N].

---
 rtl/inverse_lifting_block_pkg.sv | 16 +
 rtl/ilwt_lift_alu.sv | 33 +++
 rtl/inverse_lifting_block.sv | 104 ++++++++++
 tb/tb_inverse_lifting_block.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inverse_lifting_block_pkg.sv
// Shared types and helpers for the inverse 5/3 lifting datapath.
package inverse_lifting_block_pkg;
  localparam int DATA_W_DEF = 32;
  // Working width for lifting sums; must be at least DATA_W+2.
  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    FILL, WAIT, OUT_E, OUT_O, TAIL_E, TAIL_O
  } ilwt_state_t;

  // Arithmetic right shift: floor division by 2**sh on a sign-extended sum.
  function automatic logic signed [MAX_W-1:0] asr(input logic signed [MAX_W-1:0] s,
                                                  input int unsigned sh);
    return s >>> sh;
  endfunction
endpackage

// File: rtl/ilwt_lift_alu.sv
// Combinational lifting arithmetic: even update, odd predict and mirrored tail odd.
module ilwt_lift_alu
  import inverse_lifting_block_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              first,
  input  logic [DATA_W-1:0] an,
  input  logic [DATA_W-1:0] dn,
  input  logic [DATA_W-1:0] e_prev,
  input  logic [DATA_W-1:0] e_cur,
  input  logic [DATA_W-1:0] d_prev,
  input  logic [DATA_W-1:0] d_cur,
  output logic [DATA_W-1:0] e_new,
  output logic [DATA_W-1:0] odd,
  output logic [DATA_W-1:0] tail_odd
);
  function automatic logic signed [MAX_W-1:0] sx(input logic [DATA_W-1:0] v);
    return MAX_W'($signed(v));
  endfunction

  logic signed [MAX_W-1:0] s_upd;
  logic signed [MAX_W-1:0] s_pred;

  always_comb begin
    // Pair 0 has no left neighbour: mirror d[-1] = d[0].
    s_upd    = sx(first ? dn : d_cur) + sx(dn) + MAX_W'(2);
    s_pred   = sx(e_prev) + sx(e_cur);
    e_new    = DATA_W'(sx(an) - asr(s_upd, 2));
    odd      = DATA_W'(sx(d_prev) + asr(s_pred, 1));
    tail_odd = DATA_W'(sx(d_cur) + sx(e_cur));
  end
endmodule

// File: rtl/inverse_lifting_block.sv
// Streaming inverse integer 5/3 lifting: (a[n], d[n]) pairs in, x[0..2N+1] samples out.
module inverse_lifting_block
  import inverse_lifting_block_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] an,
  input  logic [DATA_W-1:0] dn,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] xn,
  output logic              out_last
);
  ilwt_state_t       state;
  logic [DATA_W-1:0] e_prev, e_cur, d_prev, d_cur;
  logic [DATA_W-1:0] e_new, odd, tail_odd;
  logic              last_flag;
  logic              take;

  assign in_ready = (state == FILL) || (state == WAIT);
  assign take     = in_ready && in_valid;

  ilwt_lift_alu #(.DATA_W(DATA_W)) u_alu (
    .first    (state == FILL),
    .an       (an),
    .dn       (dn),
    .e_prev   (e_prev),
    .e_cur    (e_cur),
    .d_prev   (d_prev),
    .d_cur    (d_cur),
    .e_new    (e_new),
    .odd      (odd),
    .tail_odd (tail_odd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      e_prev    <= '0;
      e_cur     <= '0;
      d_prev    <= '0;
      d_cur     <= '0;
      last_flag <= 1'b0;
      out_valid <= 1'b0;
      xn        <= '0;
      out_last  <= 1'b0;
    end else begin
      if (take) begin
        d_prev    <= d_cur;
        d_cur     <= dn;
        e_prev    <= e_cur;
        e_cur     <= e_new;
        last_flag <= last_flag | in_last;
      end
      case (state)
        FILL: if (in_valid) begin
          if (in_last) begin
            state     <= TAIL_E;
            out_valid <= 1'b1;
            xn        <= e_new;
          end else begin
            state <= WAIT;
          end
        end
        // e_cur becomes e_prev on this accept, so it is x[2n-2].
        WAIT: if (in_valid) begin
          state     <= OUT_E;
          out_valid <= 1'b1;
          xn        <= e_cur;
        end
        OUT_E: if (out_ready) begin
          state <= OUT_O;
          xn    <= odd;
        end
        OUT_O: if (out_ready) begin
          if (last_flag) begin
            state <= TAIL_E;
            xn    <= e_cur;
          end else begin
            state     <= WAIT;
            out_valid <= 1'b0;
          end
        end
        TAIL_E: if (out_ready) begin
          state    <= TAIL_O;
          xn       <= tail_odd;
          out_last <= 1'b1;
        end
        TAIL_O: if (out_ready) begin
          state     <= FILL;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          last_flag <= 1'b0;
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_inverse_lifting_block.sv
// Scoreboard bench for inverse_lifting_block: directed frames, stalls, round trip, resets.
module tb_inverse_lifting_block;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] an;
  logic [W-1:0] dn;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] xn;
  logic         out_last;

  inverse_lifting_block #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .an        (an),
    .dn        (dn),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xn        (xn),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] x;
    logic         last;
  } exp_t;

  exp_t         q[$];
  int           errors = 0;
  int           checks = 0;
  int           n_samples = 0;
  logic         stall_mode = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_xn;
  logic         prev_last;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic push(input logic [W-1:0] x, input logic last);
    exp_t e;
    e.x    = x;
    e.last = last;
    q.push_back(e);
  endtask

  // Presents a pair and returns just after the edge that accepts it.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] d, input logic last);
    int cyc = 0;
    an       = a;
    dn       = d;
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) begin
      chk1("send_timeout", in_ready, 1'b1);
      return;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int cyc = 0;
    while (q.size() != 0 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    if (q.size() != 0) chk("drain_timeout", W'(q.size()), '0);
  endtask

  // Ready generator: one-in-four acceptance when stalling.
  initial begin
    int ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode) begin
        ph = (ph + 1) % 4;
        out_ready = (ph == 3);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: checks samples in order and stability while stalled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else if (out_valid) begin
        chk1("in_ready_low", in_ready, 1'b0);
        if (prev_stall) begin
          chk("stall_xn", xn, prev_xn);
          chk1("stall_last", out_last, prev_last);
        end
        if (out_ready) begin
          prev_stall = 1'b0;
          if (q.size() == 0) begin
            chk("unexpected_sample", xn, 'x);
          end else begin
            e = q.pop_front();
            chk("sample", xn, e.x);
            chk1("last", out_last, e.last);
            n_samples++;
          end
        end else begin
          prev_stall = 1'b1;
          prev_xn    = xn;
          prev_last  = out_last;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  longint xs[64];
  longint ds[32];
  longint as_[32];

  initial begin
    int base;
    int cyc;
    // A handshake offered during reset must not be taken.
    rst      = 1'b1;
    in_valid = 1'b1;
    an       = 32'd100;
    dn       = 32'd7;
    in_last  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_xn", xn, '0);
    chk1("rst_out_last", out_last, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("reset_wins", out_valid, 1'b0);

    // Two-pair frame: e0=9, e1=18, odd=2+floor(27/2)=15, tail=4+18=22.
    push(32'd9, 1'b0); push(32'd15, 1'b0); push(32'd18, 1'b0); push(32'd22, 1'b1);
    send(32'd10, 32'd2, 1'b0);
    send(32'd20, 32'd4, 1'b1);
    in_valid = 1'b0;
    drain();

    // Single pair: floor(-4/4)=-1 so e=6, tail=-3+6=3.
    push(32'd6, 1'b0); push(32'd3, 1'b1);
    send(32'd5, -32'sd3, 1'b1);
    in_valid = 1'b0;
    drain();

    stall_mode = 1'b1;
    push(32'd9, 1'b0); push(32'd15, 1'b0); push(32'd18, 1'b0); push(32'd22, 1'b1);
    send(32'd10, 32'd2, 1'b0);
    send(32'd20, 32'd4, 1'b1);
    in_valid = 1'b0;
    drain();
    stall_mode = 1'b0;

    // Wrap: floor(-6/4)=-2, e=0x7FFFFFFF+2 wraps, tail=e-4.
    push(32'h80000001, 1'b0); push(32'h7FFFFFFD, 1'b1);
    send(32'h7FFFFFFF, -32'sd4, 1'b1);
    in_valid = 1'b0;
    drain();

    // Round trip through a forward 5/3 model, frames back to back.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 64; i++) xs[i] = longint'($urandom_range(0, 2097151)) - 1048576;
      for (int n = 0; n < 32; n++)
        ds[n] = xs[2*n+1] - ((xs[2*n] + ((n == 31) ? xs[62] : xs[2*n+2])) >>> 1);
      for (int n = 0; n < 32; n++)
        as_[n] = xs[2*n] + ((((n == 0) ? ds[0] : ds[n-1]) + ds[n] + 2) >>> 2);
      for (int i = 0; i < 64; i++) push(W'(xs[i]), i == 63);
      for (int n = 0; n < 32; n++) send(W'(as_[n]), W'(ds[n]), n == 31);
    end
    in_valid = 1'b0;
    drain();

    // Reset after the first sample of a frame discards the rest.
    base = n_samples;
    push(32'd9, 1'b0); push(32'd15, 1'b0); push(32'd18, 1'b0); push(32'd22, 1'b1);
    send(32'd10, 32'd2, 1'b0);
    send(32'd20, 32'd4, 1'b1);
    in_valid = 1'b0;
    cyc = 0;
    while (n_samples < base + 1 && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    chk("first_sample_seen", W'(n_samples - base), W'(1));
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    q.delete();
    push(32'd6, 1'b0); push(32'd3, 1'b1);
    send(32'd5, -32'sd3, 1'b1);
    in_valid = 1'b0;
    drain();

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", W'(q.size()), '0);
    chk1("idle_out_valid", out_valid, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
